// File: rtl/loss_seq_ctrl.sv
// Batch sequencer for the softmax/log-loss datapath: issues one held vector at a time,
// strobes the accumulator and captures the final loss. Optional: LOSS_PERF_CNT_EN (busy-cycle counter).
module loss_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int FWD_LAT = 36,
  parameter int ACC_LAT = 14,
  parameter int DIV_LAT = 6,
  parameter int LOG_LAT = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  output logic                  busy,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH*32-1:0]   s_vec,
  input  logic [31:0]           s_corr,
  input  logic [7:0]            s_id,
  output logic                  dp_reset_n,
  output logic [WIDTH*32-1:0]   dp_all_clsf,
  output logic [31:0]           dp_corr_clsf,
  output logic [7:0]            dp_in_id,
  output logic                  dp_f_overall_sum,
  input  logic [31:0]           dp_data_out,
  output logic                  loss_valid,
  output logic [31:0]           loss,
  output logic [7:0]            loss_id,
  output logic [31:0]           perf_cycles
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, TAIL, DONE} state_t;

  // Timer reload values: WAIT strobes when the timer reaches zero, TAIL captures one cycle before DONE.
  localparam int TMR_W      = 16;
  localparam int STROBE_DLY = FWD_LAT + ACC_LAT;
  localparam int TAIL_DLY   = DIV_LAT + LOG_LAT - 2;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [TMR_W-1:0]  timer;
  logic              handshake;
  logic              capture;

  assign handshake = s_valid && s_ready;
  assign capture   = (state == TAIL) && (timer == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt        = state;
    busy             = (state != IDLE);
    s_ready          = 1'b0;
    dp_f_overall_sum = 1'b0;
    loss_valid       = 1'b0;
    dp_reset_n       = !(reset || state == CLEAR);
    unique case (state)
      IDLE:  if (start && num_samples != '0) state_nxt = CLEAR;
      CLEAR: state_nxt = ISSUE;
      ISSUE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (timer == '0) begin
          dp_f_overall_sum = 1'b1;
          state_nxt        = (remaining != '0) ? ISSUE : TAIL;
        end
      end
      TAIL:  if (timer == '0) state_nxt = DONE;
      DONE: begin
        loss_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining-sample count is decremented at the handshake, so it reads zero at the last strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      timer     <= '0;
    end else begin
      if (state == IDLE && start && num_samples != '0) remaining <= num_samples;
      else if (handshake)                              remaining <= remaining - 1'b1;

      if (handshake)                                   timer <= TMR_W'(STROBE_DLY);
      else if (dp_f_overall_sum && remaining == '0)    timer <= TMR_W'(TAIL_DLY);
      else if (timer != '0)                            timer <= timer - 1'b1;
    end
  end

  // Holds stay put from the handshake until the next one, covering the whole forward latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_all_clsf  <= '0;
      dp_corr_clsf <= '0;
      dp_in_id     <= '0;
      loss         <= '0;
      loss_id      <= '0;
    end else begin
      if (handshake) begin
        dp_all_clsf  <= s_vec;
        dp_corr_clsf <= s_corr;
        dp_in_id     <= s_id;
      end
      if (capture) begin
        loss    <= dp_data_out;
        loss_id <= dp_in_id;
      end
    end
  end

`ifdef LOSS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                   perf_cycles <= '0;
    else if (state == IDLE && state_nxt == CLEAR) perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
  end
`else
  assign perf_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_loss_seq_ctrl.sv
// Scoreboard bench for loss_seq_ctrl: the driver queues expected strobes/losses at each
// handshake, a monitor pops and compares whenever the DUT pulses an output.
module tb_loss_seq_ctrl;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 16;
  localparam int FWD_LAT = 36;
  localparam int ACC_LAT = 14;
  localparam int DIV_LAT = 6;
  localparam int LOG_LAT = 21;
  localparam int HS_TO_F = FWD_LAT + ACC_LAT + 1;  // handshake cycle -> strobe cycle
  localparam int PERIOD  = FWD_LAT + ACC_LAT + 2;  // back-to-back handshake spacing
  localparam int F_TO_LV = DIV_LAT + LOG_LAT;      // last strobe -> loss_valid
  localparam int BUDGET  = 300;

  typedef struct {
    int                  cyc;
    logic [WIDTH*32-1:0] vec;
    logic [31:0]         corr;
    logic [7:0]          id;
  } f_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] loss;
    logic [7:0]  id;
  } l_exp_t;

  logic                clk = 0;
  logic                reset = 1;
  logic                start = 0;
  logic [CNT_W-1:0]    num_samples = '0;
  logic                busy;
  logic                s_valid = 0;
  logic                s_ready;
  logic [WIDTH*32-1:0] s_vec = '0;
  logic [31:0]         s_corr = '0;
  logic [7:0]          s_id = '0;
  logic                dp_reset_n;
  logic [WIDTH*32-1:0] dp_all_clsf;
  logic [31:0]         dp_corr_clsf;
  logic [7:0]          dp_in_id;
  logic                dp_f_overall_sum;
  logic [31:0]         dp_data_out = '0;
  logic                loss_valid;
  logic [31:0]         loss;
  logic [7:0]          loss_id;
  logic [31:0]         perf_cycles;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     clr_cycles = 0;
  int     batches = 0;
  f_exp_t fq[$];
  l_exp_t lq[$];
  int     hs_q[$];

  loss_seq_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .FWD_LAT(FWD_LAT),
    .ACC_LAT(ACC_LAT), .DIV_LAT(DIV_LAT), .LOG_LAT(LOG_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_samples(num_samples), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_vec(s_vec), .s_corr(s_corr), .s_id(s_id),
    .dp_reset_n(dp_reset_n), .dp_all_clsf(dp_all_clsf), .dp_corr_clsf(dp_corr_clsf),
    .dp_in_id(dp_in_id), .dp_f_overall_sum(dp_f_overall_sum), .dp_data_out(dp_data_out),
    .loss_valid(loss_valid), .loss(loss), .loss_id(loss_id), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int c);
    return 32'h4005_0000 ^ 32'(c);
  endfunction

  function automatic logic [WIDTH*32-1:0] vec_of(input logic [7:0] id);
    logic [WIDTH*32-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[32*i +: 32] = {id, 8'(i), 16'hC0DE};
    return v;
  endfunction

  function automatic logic [31:0] corr_of(input logic [7:0] id);
    return {16'hBEEF, 8'h00, id};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stand-in datapath result: a cycle-dependent word, so the capture cycle is observable.
  initial forever begin
    @(negedge clk);
    dp_data_out = pat(cyc);
  end

  // Monitor: pops an expectation on every strobe / loss pulse.
  initial begin
    bit expect_idle = 0;
    f_exp_t fe;
    l_exp_t le;
    forever begin
      @(negedge clk);
      if (!reset && !dp_reset_n) clr_cycles++;
      if (expect_idle) begin
        check("busy_after_loss_valid", busy, 0);
        expect_idle = 0;
      end
      if (dp_f_overall_sum) begin
        check("f_expected_pending", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          fe = fq.pop_front();
          check("f_cycle", cyc, fe.cyc);
          check("f_hold_vec", dp_all_clsf, fe.vec);
          check("f_hold_corr", dp_corr_clsf, fe.corr);
          check("f_hold_id", dp_in_id, fe.id);
        end
      end
      if (loss_valid) begin
        check("loss_expected_pending", lq.size() != 0, 1);
        if (lq.size() != 0) begin
          le = lq.pop_front();
          check("loss_valid_cycle", cyc, le.cyc);
          check("loss_value", loss, le.loss);
          check("loss_id", loss_id, le.id);
        end
        expect_idle = 1;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int t = 0; t < BUDGET; t++) begin
      if (s_ready) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
    check("s_ready_timeout", s_ready, 1);
  endtask

  // Runs one batch from IDLE; a nonzero stall delays the second sample after s_ready returns.
  task automatic do_batch(input int n, input int stall, input logic [7:0] id0);
    bit ok;
    int h;
    logic [7:0] id;
    f_exp_t fe;
    l_exp_t le;
    hs_q.delete();
    start = 1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start = 0;
    batches++;
    for (int k = 0; k < n; k++) begin
      id = id0 + 8'(k);
      if (k == 1 && stall > 0) begin
        wait_ready(ok);
        if (!ok) return;
        repeat (stall) @(negedge clk);
        check("stall_hold_vec", dp_all_clsf, vec_of(id0));
        check("stall_hold_id", dp_in_id, id0);
      end
      s_valid = 1;
      s_vec   = vec_of(id);
      s_corr  = corr_of(id);
      s_id    = id;
      wait_ready(ok);
      if (!ok) return;
      h = cyc;
      hs_q.push_back(h);
      fe.cyc = h + HS_TO_F; fe.vec = s_vec; fe.corr = s_corr; fe.id = id;
      fq.push_back(fe);
      if (k == n - 1) begin
        le.cyc = h + HS_TO_F + F_TO_LV; le.loss = pat(le.cyc - 1); le.id = id;
        lq.push_back(le);
      end
      @(negedge clk);
      s_valid = 0;
    end
    for (int t = 0; t < BUDGET && (fq.size() != 0 || lq.size() != 0); t++) @(negedge clk);
    check("drain_f_queue", fq.size(), 0);
    check("drain_loss_queue", lq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dp_reset_n", dp_reset_n, 0);
    check("reset_busy", busy, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_loss", loss, 0);
    check("reset_hold_vec", dp_all_clsf, 0);
    check("reset_perf", perf_cycles, 0);
    reset = 0;
    @(negedge clk);
    check("idle_dp_reset_n", dp_reset_n, 1);
    check("idle_f", dp_f_overall_sum, 0);
    check("idle_loss_valid", loss_valid, 0);

    // 1) single sample
    do_batch(1, 0, 8'h05);
`ifdef LOSS_PERF_CNT_EN
    check("perf_scn1", perf_cycles, FWD_LAT + ACC_LAT + DIV_LAT + LOG_LAT + 3);
    repeat (5) @(negedge clk);
    check("perf_scn1_hold", perf_cycles, FWD_LAT + ACC_LAT + DIV_LAT + LOG_LAT + 3);
`else
    check("perf_disabled", perf_cycles, 0);
`endif

    // 2) three back-to-back samples
    do_batch(3, 0, 8'h10);
    check("hs_count_scn2", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("period_1_2", hs_q[1] - hs_q[0], PERIOD);
      check("period_2_3", hs_q[2] - hs_q[1], PERIOD);
    end

    // 3) stalled second sample
    do_batch(2, 10, 8'h20);
    if (hs_q.size() == 2) check("period_stalled", hs_q[1] - hs_q[0], PERIOD + 10);

    // 4) reset mid-batch, then a fresh single-sample batch
    start = 1;
    num_samples = 4;
    @(negedge clk);
    start = 0;
    batches++;
    s_valid = 1; s_vec = vec_of(8'h40); s_corr = corr_of(8'h40); s_id = 8'h40;
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    s_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_loss_cleared", loss, 0);
    check("abort_hold_cleared", dp_in_id, 0);
    repeat (60) @(negedge clk);
    check("abort_still_idle", busy, 0);
    do_batch(1, 0, 8'h05);

    // 5) ignored starts: zero batch size, while busy, and in DONE
    start = 1;
    num_samples = 0;
    @(negedge clk);
    start = 0;
    check("zero_n_busy", busy, 0);
    check("zero_n_dp_reset_n", dp_reset_n, 1);
    fork
      do_batch(1, 0, 8'h33);
      begin
        repeat (30) @(negedge clk);
        start = 1;
        num_samples = 5;
        @(negedge clk);
        start = 0;
        for (int t = 0; t < BUDGET; t++) begin
          if (loss_valid) break;
          @(negedge clk);
        end
        start = 1;
        num_samples = 3;
        @(negedge clk);
        start = 0;
        check("start_in_done_ignored", busy, 0);
      end
    join
    repeat (5) @(negedge clk);
    check("final_idle", busy, 0);
    check("clear_pulse_count", clr_cycles, batches);
    check("final_f_queue_empty", fq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
